boss_danmaku: RTL
=================

Name: boss_danmaku

Overview:
- Enemy-side bullet engine: the reverse direction of the player shot path. The boss fires a 4-slot fan of bullets downward, the block detects hits on reimu, and it decrements reimu's life count.
- Ticks on clk_22 (one movement step per cycle).
- Outputs feed the VGA renderer (bullet positions and valid bits) and the game-state/score logic (life, invincibility, game over).

Parameters:
- FIRE_PERIOD, 32: cycles between fire attempts.
- INV_TICKS, 64: invincibility length after a hit, in cycles.
- LIVES, 3: initial life count (max 7).
- HIT_R, 6: half-width in px of the square reimu hitbox.
- SPEED, 3: downward px per cycle for every bullet.

Ports:
- clk_22  in  1  game tick clock
- rst  in  1  synchronous, active-high reset
- bossE  in  1  boss stage active; enables firing and movement
- bossx  in  10  boss centre x
- bossy  in  10  boss centre y
- bosshp  in  10  boss HP; firing only while nonzero
- reimux  in  10  reimu centre x
- reimuy  in  10  reimu centre y
- boss_bulletx  out  40  slot i x at bits [10i+9:10i]
- boss_bullety  out  40  slot i y at bits [10i+9:10i]
- boss_bullet  out  4  slot valid bits
- reimu_life  out  3  remaining lives
- reimu_inv  out  1  high while invincible
- game_over  out  1  high in DEAD state

Behaviour:
- Reset (rst=1 at a clk_22 edge; overrides everything, including mid-flight):
  - all x/y = 0, boss_bullet = 0
  - reimu_life = LIVES, reimu_inv = 0, game_over = 0
  - fire counter = 0, invincibility counter = 0, state ALIVE
- Horizontal drift per slot: slot0 −2, slot1 −1, slot2 +1, slot3 +2 px per cycle.
- Hit test uses the current registered positions, in 11-bit arithmetic with no underflow: bx+HIT_R >= reimux, bx <= reimux+HIT_R, by+HIT_R >= reimuy, by <= reimuy+HIT_R.
- bossE=0: all valid bits clear next cycle; fire counter is held at 0. Lives and state are unaffected; the invincibility counter still runs.
- Per valid slot each cycle, bossE=1, priority order:
  1. Hit: state ALIVE and the hit test is true → slot cleared, hit flagged.
  2. Off-screen: y >= 480−SPEED, or x < 2, or x > 637 → slot cleared.
  3. Otherwise: y += SPEED, x += the slot's drift.
- Fire counter:
  - Counts 0..FIRE_PERIOD−1 while bossE=1, then wraps to 0.
  - At the wrap cycle, if bosshp != 0 and state != DEAD, spawn into the lowest-index slot that is invalid in the current registered state.
  - Spawn position: x = bossx, y = bossy+16; valid next cycle.
  - No free slot → that shot is dropped; no queuing.
  - A slot cleared in this cycle is not reused until the next cycle.
- Life FSM:
  - ALIVE:
    - Any hit flag this cycle (one or several slots) → reimu_life −1, exactly once.
    - New life 0 → DEAD.
    - Otherwise → INVINCIBLE, invincibility counter loaded with INV_TICKS−1.
  - INVINCIBLE:
    - reimu_inv = 1.
    - No hit detection; bullets pass through reimu.
    - Counter decrements each cycle; at 0 → ALIVE on the next edge. Invincibility therefore lasts INV_TICKS cycles.
  - DEAD:
    - game_over = 1, reimu_inv = 0.
    - No spawns and no hits; live bullets keep moving until they leave the screen.
    - Left only by rst.
- reimu_life saturates at 0 and never wraps.
- Latency: a hit registered at edge N shows reimu_life updated and the slot invalid at edge N+1.
- Registered next-state style: one sequential block plus combinational next-state logic; no latches (all next values assigned on every path).

Test Plan:
- Fire and move:
  - Stimulus: rst, then bossE=1, bosshp=450, boss at (320,100), reimu at (320,460).
  - Required: slot0 valid after 32 cycles at (320,116); next cycle (318,119). Slot1 fires after 64 cycles at (320,116).
- Single hit:
  - Stimulus: reimu at (318,119) at the cycle slot0 sits there.
  - Required: next cycle reimu_life 3→2, slot0 invalid, reimu_inv=1 for exactly 64 cycles, then 0.
- Simultaneous hits:
  - Stimulus: place reimu so slots 1 and 2 both fall inside the hitbox in the same cycle.
  - Required: life decrements by 1 only; both slots cleared.
- Pool full:
  - Stimulus: reimu far away at (0,0); run until all 4 slots are valid with none off-screen at a fire event.
  - Required: no spawn; lowest freed slot is reused at the next wrap after it clears.
- Game over:
  - Stimulus: three hits spaced more than 64 cycles apart.
  - Required: reimu_life=0, game_over=1, no new valid bits, remaining bullets exit the screen. With bosshp=0, no spawns occur at any time.
- Reset mid-operation:
  - Stimulus: assert rst while INVINCIBLE with 3 bullets live.
  - Required: next cycle all outputs equal their reset values (life=3, inv=0, boss_bullet=0).

Source files
------------

// File: rtl/boss_danmaku_if.sv
// Bus between the boss bullet engine and its surroundings: boss/reimu positions in,
// bullet pool and life/invincibility status out.
interface boss_danmaku_if;
  logic        bossE;
  logic [9:0]  bossx;
  logic [9:0]  bossy;
  logic [9:0]  bosshp;
  logic [9:0]  reimux;
  logic [9:0]  reimuy;
  logic [39:0] boss_bulletx;
  logic [39:0] boss_bullety;
  logic [3:0]  boss_bullet;
  logic [2:0]  reimu_life;
  logic        reimu_inv;
  logic        game_over;

  modport master (
    output bossE, bossx, bossy, bosshp, reimux, reimuy,
    input  boss_bulletx, boss_bullety, boss_bullet, reimu_life, reimu_inv, game_over
  );

  modport slave (
    input  bossE, bossx, bossy, bosshp, reimux, reimuy,
    output boss_bulletx, boss_bullety, boss_bullet, reimu_life, reimu_inv, game_over
  );
endinterface

// File: rtl/boss_danmaku.sv
// Boss bullet engine: four-slot downward fan, square-hitbox collision against reimu,
// and the ALIVE/INVINCIBLE/DEAD life state machine. One movement step per clk_22 tick.
module boss_danmaku #(
  parameter int FIRE_PERIOD = 32,
  parameter int INV_TICKS   = 64,
  parameter int LIVES       = 3,
  parameter int HIT_R       = 6,
  parameter int SPEED       = 3
) (
  input logic           clk_22,
  input logic           rst,
  boss_danmaku_if.slave bus
);

  localparam int FCW = $clog2(FIRE_PERIOD + 1);
  localparam int ICW = $clog2(INV_TICKS + 1);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_INV   = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  logic [9:0]     r_x [4];
  logic [9:0]     r_y [4];
  logic [3:0]     r_valid;
  logic [2:0]     r_life;
  state_t         r_state;
  logic [FCW-1:0] r_fire_cnt;
  logic [ICW-1:0] r_inv_cnt;
  logic           r_inv;
  logic           r_game_over;

  logic [9:0]     w_x [4];
  logic [9:0]     w_y [4];
  logic [3:0]     w_valid;
  logic [3:0]     w_hit;
  logic [3:0]     w_spawn;
  logic           w_wrap;
  logic           w_fire;
  logic [FCW-1:0] w_fire_cnt;
  logic [2:0]     w_life;
  logic [2:0]     w_life_dec;
  state_t         w_state;
  logic [ICW-1:0] w_inv_cnt;

  // 11-bit compares so that the +HIT_R sums cannot wrap near the screen edges
  function automatic logic hit_test(input logic [9:0] bx, input logic [9:0] by,
                                    input logic [9:0] rx, input logic [9:0] ry);
    logic [10:0] hr;
    hr = 11'(HIT_R);
    return ({1'b0, bx} + hr >= {1'b0, rx}) && ({1'b0, bx} <= {1'b0, rx} + hr) &&
           ({1'b0, by} + hr >= {1'b0, ry}) && ({1'b0, by} <= {1'b0, ry} + hr);
  endfunction

  function automatic logic off_screen(input logic [9:0] bx, input logic [9:0] by);
    return (by >= 10'(480 - SPEED)) || (bx < 10'd2) || (bx > 10'd637);
  endfunction

  function automatic logic [9:0] drift(input logic [1:0] slot, input logic [9:0] x);
    case (slot)
      2'd0:    return x - 10'd2;
      2'd1:    return x - 10'd1;
      2'd2:    return x + 10'd1;
      2'd3:    return x + 10'd2;
      default: return x;
    endcase
  endfunction

  assign w_wrap     = (r_fire_cnt == FCW'(FIRE_PERIOD - 1));
  assign w_fire_cnt = !bus.bossE ? '0 : (w_wrap ? '0 : r_fire_cnt + FCW'(1));
  assign w_fire     = bus.bossE && w_wrap && (bus.bosshp != 10'd0) && (r_state != ST_DEAD);
  // lowest invalid slot in the registered state: (~v) & (v + 1) isolates the lowest zero
  assign w_spawn    = w_fire ? (~r_valid & (r_valid + 4'd1)) : 4'd0;
  assign w_life_dec = (r_life != 3'd0) ? r_life - 3'd1 : 3'd0;

  // Per-slot spawn / hit / exit / move
  always_comb begin
    w_x     = r_x;
    w_y     = r_y;
    w_valid = r_valid;
    w_hit   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.bossE) begin
        w_valid[i] = 1'b0;
      end else if (w_spawn[i]) begin
        w_x[i]     = bus.bossx;
        w_y[i]     = bus.bossy + 10'd16;
        w_valid[i] = 1'b1;
      end else if (r_valid[i] && (r_state == ST_ALIVE) &&
                   hit_test(r_x[i], r_y[i], bus.reimux, bus.reimuy)) begin
        w_valid[i] = 1'b0;
        w_hit[i]   = 1'b1;
      end else if (r_valid[i] && off_screen(r_x[i], r_y[i])) begin
        w_valid[i] = 1'b0;
      end else if (r_valid[i]) begin
        w_x[i] = drift(2'(i), r_x[i]);
        w_y[i] = r_y[i] + 10'(SPEED);
      end else begin
        w_valid[i] = 1'b0;
      end
    end
  end

  // Life FSM next state; several simultaneous hits cost a single life
  always_comb begin
    w_state   = r_state;
    w_life    = r_life;
    w_inv_cnt = r_inv_cnt;
    case (r_state)
      ST_ALIVE: begin
        if (|w_hit) begin
          w_life = w_life_dec;
          if (w_life_dec == 3'd0) begin
            w_state = ST_DEAD;
          end else begin
            w_state   = ST_INV;
            w_inv_cnt = ICW'(INV_TICKS - 1);
          end
        end else begin
          w_state = ST_ALIVE;
        end
      end
      ST_INV: begin
        if (r_inv_cnt == '0) begin
          w_state = ST_ALIVE;
        end else begin
          w_inv_cnt = r_inv_cnt - ICW'(1);
        end
      end
      ST_DEAD: w_state = ST_DEAD;
      default: w_state = ST_ALIVE;
    endcase
  end

  // State registers; status outputs registered from the next state
  always_ff @(posedge clk_22) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= 10'd0;
        r_y[i] <= 10'd0;
      end
      r_valid     <= 4'd0;
      r_life      <= 3'(LIVES);
      r_state     <= ST_ALIVE;
      r_fire_cnt  <= '0;
      r_inv_cnt   <= '0;
      r_inv       <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_x         <= w_x;
      r_y         <= w_y;
      r_valid     <= w_valid;
      r_life      <= w_life;
      r_state     <= w_state;
      r_fire_cnt  <= w_fire_cnt;
      r_inv_cnt   <= w_inv_cnt;
      r_inv       <= (w_state == ST_INV);
      r_game_over <= (w_state == ST_DEAD);
    end
  end

  assign bus.boss_bulletx = {r_x[3], r_x[2], r_x[1], r_x[0]};
  assign bus.boss_bullety = {r_y[3], r_y[2], r_y[1], r_y[0]};
  assign bus.boss_bullet  = r_valid;
  assign bus.reimu_life   = r_life;
  assign bus.reimu_inv    = r_inv;
  assign bus.game_over    = r_game_over;

endmodule
